// File: rtl/penc_drain.sv
// penc_drain: latches a multi-hot vector and drains it as a stream of set-bit indices.
// Optional macro PENC_DRAIN_BYPASS_EN: accept the next vector on the final index (no bubble).
module penc_drain #(
  parameter int LEN       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2**LEN-1:0]   in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN-1:0]      out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam int OPT = 2**LEN;
  localparam logic [OPT-1:0] ONE = {{(OPT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt;
  logic [OPT-1:0]   pending_r;
  logic [OPT-1:0]   pending_nxt;
  logic [LEN-1:0]   out_idx_r;
  logic             out_last_r;

  // The last matching bit of the scan wins, so scan direction selects MIN or MAX order.
  function automatic logic [LEN-1:0] penc(input logic [OPT-1:0] vec);
    logic [LEN-1:0] idx;
    int k;
    idx = '0;
    for (int i = 0; i < OPT; i++) begin
      k = MSB_FIRST ? i : (OPT - 1 - i);
      if (vec[k]) begin
        idx = LEN'(k);
      end
    end
    return idx;
  endfunction

  function automatic logic is_last(input logic [OPT-1:0] vec);
    return (vec != '0) && ((vec & (vec - ONE)) == '0);
  endfunction

  // Next-state, next-pending and input-ready decode.
  always_comb begin
    state_nxt   = state_r;
    pending_nxt = pending_r;
    in_ready    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_nxt = in_vec;
          state_nxt   = (in_vec != '0) ? EMIT : IDLE;
        end else begin
          pending_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_nxt = pending_r & ~(ONE << out_idx_r);
          if (out_last_r) begin
`ifdef PENC_DRAIN_BYPASS_EN
            in_ready = 1'b1;
            if (in_valid) begin
              pending_nxt = in_vec;
              state_nxt   = (in_vec != '0) ? EMIT : IDLE;
            end else begin
              state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
          end else begin
            state_nxt = EMIT;
          end
        end else begin
          pending_nxt = pending_r;
          state_nxt   = EMIT;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // Index and last flag are precomputed from the next pending vector so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pending_r  <= '0;
      out_idx_r  <= '0;
      out_last_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      pending_r  <= pending_nxt;
      out_idx_r  <= penc(pending_nxt);
      out_last_r <= is_last(pending_nxt);
    end
  end

  assign out_valid = (state_r == EMIT);
  assign busy      = (state_r == EMIT);
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_penc_drain.sv
// Directed bench for penc_drain: one MIN-order and one MAX-order instance share all inputs.
module tb_penc_drain;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        out_ready;
  logic        in_ready0, out_valid0, out_last0, busy0;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [3:0]  out_idx0, out_idx1;
  int          n_chk;
  int          n_fail;

  penc_drain #(.LEN(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0), .out_last(out_last0),
    .busy(busy0)
  );

  penc_drain #(.LEN(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1), .out_last(out_last1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 16'h0000; out_ready = 1'b1;
    #12;
    n_chk++;
    if ({out_valid0, out_idx0, out_last0, busy0, out_valid1, out_idx1, out_last1, busy1} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v%b i%0d l%b b%b / v%b i%0d l%b b%b want all 0",
               out_valid0, out_idx0, out_last0, busy0, out_valid1, out_idx1, out_last1, busy1);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_chk++;
    if ({in_ready0, in_ready1, out_valid0, out_valid1} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release got rdy %b%b vld %b%b want rdy 11 vld 00", in_ready0, in_ready1, out_valid0, out_valid1);
    end
  endtask

  task automatic test_drain_8421();
    logic [3:0] e0 [4];
    logic [3:0] e1 [4];
    e0 = '{4'd0, 4'd5, 4'd10, 4'd15};
    e1 = '{4'd15, 4'd10, 4'd5, 4'd0};
    in_valid = 1'b1; in_vec = 16'h8421; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_vec = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({out_valid0, busy0, in_ready0, out_idx0, out_last0} !== {1'b1, 1'b1, 1'b0, e0[i], (i == 3)}) begin
        n_fail++;
        $display("FAIL drain_min[%0d] got v%b b%b r%b idx %0d last %b want v1 b1 r0 idx %0d last %b",
                 i, out_valid0, busy0, in_ready0, out_idx0, out_last0, e0[i], (i == 3));
      end
      n_chk++;
      if ({out_valid1, out_idx1, out_last1} !== {1'b1, e1[i], (i == 3)}) begin
        n_fail++;
        $display("FAIL drain_max[%0d] got v%b idx %0d last %b want v1 idx %0d last %b",
                 i, out_valid1, out_idx1, out_last1, e1[i], (i == 3));
      end
      step();
    end
    n_chk++;
    if ({out_valid0, out_valid1, in_ready0, in_ready1, out_idx0, out_last0} !== {4'b0011, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_done got vld %b%b rdy %b%b idx %0d last %b want vld 00 rdy 11 idx 0 last 0",
               out_valid0, out_valid1, in_ready0, in_ready1, out_idx0, out_last0);
    end
  endtask

  task automatic test_zero_vec();
    in_valid = 1'b1; in_vec = 16'h0000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1} !== 6'b001001) begin
        n_fail++;
        $display("FAIL zero_vec[%0d] got v%b b%b r%b / v%b b%b r%b want v0 b0 r1",
                 i, out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1);
      end
      step();
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_vec = 16'h0006; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_vec = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1} !== {1'b1, 4'd1, 1'b0, 1'b1, 4'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v%b idx %0d last %b / v%b idx %0d last %b want 1,1,0 / 1,2,0",
                 i, out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1);
      end
      step();
    end
    out_ready = 1'b1;
    n_chk++;
    if ({out_valid0, out_idx0, out_last0} !== {1'b1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_first got v%b idx %0d last %b want v1 idx 1 last 0", out_valid0, out_idx0, out_last0);
    end
    step();
    n_chk++;
    if ({out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1} !== {1'b1, 4'd2, 1'b1, 1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_second got v%b idx %0d last %b / v%b idx %0d last %b want 1,2,1 / 1,1,1",
               out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1);
    end
    step();
    n_chk++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_done got vld %b%b want 00", out_valid0, out_valid1);
    end
  endtask

  task automatic test_reset_mid_emit();
    in_valid = 1'b1; in_vec = 16'hFFFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_vec = 16'h0000;
    step();
    step();
    n_chk++;
    if ({out_valid0, out_idx0, out_valid1, out_idx1} !== {1'b1, 4'd2, 1'b1, 4'd13}) begin
      n_fail++;
      $display("FAIL ffff_third got v%b idx %0d / v%b idx %0d want 1,2 / 1,13", out_valid0, out_idx0, out_valid1, out_idx1);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid0, busy0, out_valid1, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset got v%b b%b / v%b b%b want all 0", out_valid0, busy0, out_valid1, busy1);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_chk++;
    if ({in_ready0, in_ready1, out_valid0, out_valid1} !== 4'b1100) begin
      n_fail++;
      $display("FAIL post_reset got rdy %b%b vld %b%b want rdy 11 vld 00", in_ready0, in_ready1, out_valid0, out_valid1);
    end
    in_valid = 1'b1; in_vec = 16'h0001;
    step();
    in_valid = 1'b0; in_vec = 16'h0000;
    n_chk++;
    if ({out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1} !== {1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL pending_cleared got v%b idx %0d last %b / v%b idx %0d last %b want 1,0,1",
               out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_vec = 16'h0001; out_ready = 1'b1;
    step();
    in_vec = 16'h0002;
    n_chk++;
    if ({out_valid0, out_idx0, out_last0} !== {1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_first got v%b idx %0d last %b want 1,0,1", out_valid0, out_idx0, out_last0);
    end
`ifdef PENC_DRAIN_BYPASS_EN
    n_chk++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_bypass_ready got %b%b want 11", in_ready0, in_ready1);
    end
    step();
`else
    n_chk++;
    if ({in_ready0, in_ready1} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_emit_ready got %b%b want 00", in_ready0, in_ready1);
    end
    step();
    n_chk++;
    if ({out_valid0, out_valid1, in_ready0, in_ready1} !== 4'b0011) begin
      n_fail++;
      $display("FAIL b2b_bubble got vld %b%b rdy %b%b want vld 00 rdy 11", out_valid0, out_valid1, in_ready0, in_ready1);
    end
    step();
`endif
    in_valid = 1'b0; in_vec = 16'h0000;
    n_chk++;
    if ({out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1} !== {1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second got v%b idx %0d last %b / v%b idx %0d last %b want 1,1,1",
               out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1);
    end
    step();
    n_chk++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_done got vld %b%b want 00", out_valid0, out_valid1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_drain_8421();
    test_zero_vec();
    test_stall();
    test_reset_mid_emit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
